temp_freq_counter: RTL
======================

# temp_freq_counter

Digital read-out end of the temperature-sensor path. It takes the divided ring-oscillator output from the sensor clock divider, synchronises it into the system clock domain and counts its rising edges over a fixed gate window. It latches the count as a temperature code and presents it byte-wise on the 8-bit output pins. The block sits between the analog sensor/divider and the top-level `uo_out` mux.

## Interface
- `GATE_CYCLES`, default 4096: gate window length in `clk` cycles; must be ≥ 2.
- `CNT_W`, default 16: width of the edge counter and result; must be 9..16.

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous reset, active-high; sampled on the `clk` rising edge.
- `sens_in`  in  1  divided sensor oscillator; asynchronous to `clk`.
- `start`  in  1  single-cycle request to begin one measurement.
- `continuous`  in  1  when 1, restart automatically after each result.
- `byte_sel`  in  1  0 = `dout` shows `result[7:0]`; 1 = `dout` shows the zero-extended `result[CNT_W-1:8]`.
- `dout`  out  8  selected result byte; combinational from `result` and `byte_sel`.
- `result`  out  CNT_W  last latched count.
- `valid`  out  1  one-cycle pulse when `result` updates.
- `ovf`  out  1  set when the last window saturated the counter.
- `busy`  out  1  high while in MEASURE.

## Operation
- **Input conditioning.** `sens_in` passes through a 2-flop synchroniser, then a third flop for edge detection. A rising edge is `s2 & ~s3`.
- **Input rate limit.** `sens_in` high and low phases must each exceed one `clk` period. Faster inputs undercount; this is not flagged.
- **IDLE.** `busy=0`.
  - `start | continuous` moves to MEASURE.
  - Window counter and edge counter clear on entry.
- **MEASURE.** `busy=1`.
  - Window counter increments every cycle.
  - Edge counter increments on each detected edge and saturates at 2^CNT_W−1. A sticky overflow bit is set on any attempted increment at saturation.
  - After exactly GATE_CYCLES cycles in MEASURE, go to DONE.
- **DONE** (1 cycle).
  - `result` ← edge count; `ovf` ← sticky bit; `valid=1`.
  - Next state is MEASURE if `continuous=1`, otherwise IDLE.
  - Edges detected during DONE are dropped (one-cycle dead time per window).
- **Unused start.** `start` in MEASURE or DONE is ignored; it is not queued.
- **Mode change.** Deasserting `continuous` mid-window lets the current window finish, then returns to IDLE.
- **Reset.** Takes effect from any state, including mid-window.
  - State → IDLE.
  - All counters cleared.
  - `result`=0, `ovf`=0, `valid`=0, `busy`=0, so `dout`=0x00.
  - Synchroniser flops also clear to 0.
  - An in-progress window is discarded with no `valid`.

## Timing
- **Start latency.** `start` sampled high at cycle T puts the FSM in MEASURE at T+1, so `busy`=1 from T+1.
- **Window span.** MEASURE occupies cycles T+1 .. T+GATE_CYCLES. An edge detected in cycle T+GATE_CYCLES is counted.
- **Result timing.** DONE is at T+GATE_CYCLES+1. `valid` is high and the new `result`/`ovf` are visible in that same cycle, and held until the next DONE or reset.
- **Continuous period.** In continuous mode `valid` pulses every GATE_CYCLES+1 cycles.
- **Input latency.** From a `sens_in` transition to edge detection is 2–3 `clk` cycles.
  - A count may therefore include an edge that physically occurred up to 3 cycles before the window.
  - Accepted quantisation is ±1 count.
- **Arithmetic.** The window counter is `$clog2(GATE_CYCLES+1)` bits wide and unsigned. There is no wrap: the counter is reset on every MEASURE entry.

## Structure
- **Shared package `temp_sens_pkg`:**
  - State enum {IDLE, MEASURE, DONE}.
  - Default constants `GATE_CYCLES_DEF=4096` and `CNT_W_DEF=16`.
  - Sensor-path constants for reuse by the top level.
- **Sub-module `sync_edge_det`:**
  - 2-flop synchroniser plus edge flop, with the synchronous active-high reset.
  - Output `rise` pulse.
  - Reusable for other asynchronous pins.
- FSM, counters and output mux live in `temp_freq_counter`.

## Test plan
- **Single measurement.** GATE_CYCLES=100, `sens_in` period 10 clk (5 high/5 low), `start` pulse → `valid` exactly 101 cycles after `start`; `result`=10 (±1); `ovf`=0; `busy` high for 100 cycles.
- **Saturation.** CNT_W=9, GATE_CYCLES=2000, `sens_in` period 2 clk (≈1000 edges) → `result`=511; `ovf`=1; `byte_sel`=1 gives `dout`=0x01; `byte_sel`=0 gives `dout`=0xFF.
- **Continuous mode.** GATE_CYCLES=50, `continuous`=1 held, `sens_in` period 5 → `valid` pulses every 51 cycles, each `result`=10 (±1). Drop `continuous` mid-window → one more `valid`, then IDLE with `busy`=0.
- **Reset mid-window.** Assert `rst` for 1 cycle at cycle 40 of a 100-cycle window → no `valid`; next cycle shows `result`=0, `ovf`=0, `busy`=0, `dout`=0x00. A fresh `start` then gives a correct count.
- **Ignored start.** Pulse `start` at window cycles 10 and 99 → exactly one `valid`, and the FSM returns to IDLE after DONE.
- **Zero input.** `sens_in` held at 0 or at 1 for a full window → `result`=0, `ovf`=0, `valid` still asserted on time.

Source files
------------

// File: rtl/temp_sens_pkg.sv
// Shared types and constants for the temperature-sensor read-out path.
package temp_sens_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    DONE
  } meas_state_e;

  localparam int unsigned GATE_CYCLES_DEF  = 4096;
  localparam int unsigned CNT_W_DEF        = 16;
  localparam int unsigned SENS_SYNC_STAGES = 2;
  localparam int unsigned DOUT_W           = 8;

  // Window counter must hold GATE_CYCLES without wrapping.
  function automatic int unsigned win_cnt_width(input int unsigned gate_cycles);
    return $clog2(gate_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser plus an edge flop; emits a one-cycle pulse per rising edge.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic sync1_q, sync2_q, edge_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~edge_q;

endmodule

// File: rtl/temp_freq_counter.sv
// Gated edge counter for the ring-oscillator temperature sensor; latches the
// count per window and presents it byte-wise.
module temp_freq_counter
  import temp_sens_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sens_in,
  input  logic              start,
  input  logic              continuous,
  input  logic              byte_sel,
  output logic [DOUT_W-1:0] dout,
  output logic [CNT_W-1:0]  result,
  output logic              valid,
  output logic              ovf,
  output logic              busy
);

  localparam int unsigned WIN_W          = win_cnt_width(GATE_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  if (GATE_CYCLES < 2) begin : gen_bad_gate
    $error("GATE_CYCLES must be at least 2");
  end
  if (CNT_W < 9 || CNT_W > 16) begin : gen_bad_width
    $error("CNT_W must be in 9..16");
  end

  logic rise;

  sync_edge_det u_sync_edge_det (
    .clk      (clk),
    .rst      (rst),
    .async_in (sens_in),
    .rise     (rise)
  );

  meas_state_e      state_q;
  logic [WIN_W-1:0] win_cnt_q;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             ovf_sticky_q, ovf_sticky_d;
  logic [CNT_W-1:0] result_q;
  logic             ovf_q, valid_q, busy_q;

  // Saturating edge count; a blocked increment marks the window as overflowed.
  always_comb begin
    edge_cnt_d   = edge_cnt_q;
    ovf_sticky_d = ovf_sticky_q;
    if (rise) begin
      if (edge_cnt_q == CNT_MAX) begin
        ovf_sticky_d = 1'b1;
      end else begin
        edge_cnt_d = edge_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      win_cnt_q    <= '0;
      edge_cnt_q   <= '0;
      ovf_sticky_q <= 1'b0;
      result_q     <= '0;
      ovf_q        <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start || continuous) begin
            state_q      <= MEASURE;
            busy_q       <= 1'b1;
            win_cnt_q    <= '0;
            edge_cnt_q   <= '0;
            ovf_sticky_q <= 1'b0;
          end
        end
        MEASURE: begin
          win_cnt_q <= win_cnt_q + WIN_W'(1);
          if (win_cnt_q == WIN_LAST) begin
            // Latch on the way into DONE so result and valid appear together there.
            state_q  <= DONE;
            busy_q   <= 1'b0;
            valid_q  <= 1'b1;
            result_q <= edge_cnt_d;
            ovf_q    <= ovf_sticky_d;
          end else begin
            edge_cnt_q   <= edge_cnt_d;
            ovf_sticky_q <= ovf_sticky_d;
          end
        end
        DONE: begin
          if (continuous) begin
            state_q      <= MEASURE;
            busy_q       <= 1'b1;
            win_cnt_q    <= '0;
            edge_cnt_q   <= '0;
            ovf_sticky_q <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    dout = result_q[DOUT_W-1:0];
    if (byte_sel) begin
      dout = DOUT_W'(result_q >> DOUT_W);
    end
  end

  assign result = result_q;
  assign valid  = valid_q;
  assign ovf    = ovf_q;
  assign busy   = busy_q;

endmodule
